reg_file_wb: RTL and testbench
==============================

# reg_file_wb

Write-back end of the forwarding datapath. Holds the eight general registers plus the IH, SP and T special registers, accepts one write per cycle from the MEM/WB stage, and serves two general-register read ports and the special-register values to the ID stage. Results are committed by the write-back stage and read here. A same-cycle write-through bypass lets ID read a value that WB is committing in that cycle, so the forwarding unit only has to cover the EX/MEM and MEM/WB stages.

## Interface
Parameters:
- DATA_WIDTH, 16, width of every register and data port
- SP_RESET, 16'hBF10, SP value after reset
- IH_RESET, 16'h0000, IH value after reset

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- wb_reg_op  in  3  write target: 0 NOP, 1 REG, 2 IH, 3 SP, 4 T; values 5-7 are treated as NOP
- wb_addr  in  3  general-register index; used only when wb_reg_op = REG
- wb_data  in  DATA_WIDTH  value to commit
- reg1_addr  in  3  read port 1 index
- reg2_addr  in  3  read port 2 index
- reg1_data  out  DATA_WIDTH  general register at reg1_addr, after bypass
- reg2_data  out  DATA_WIDTH  general register at reg2_addr, after bypass
- IH_data  out  DATA_WIDTH  IH, after bypass
- SP_data  out  DATA_WIDTH  SP, after bypass
- T_data  out  DATA_WIDTH  T, after bypass

## Operation
- Storage: R0-R7, IH, SP and T, each DATA_WIDTH wide.
- Reset (rst high at a rising edge):
  - R0-R7 and T become 0, IH becomes IH_RESET, SP becomes SP_RESET.
  - Any write presented in that cycle is discarded.
- Write (rst low at a rising edge):
  - REG: R[wb_addr] <= wb_data.
  - IH, SP, T: the named register <= wb_data.
  - NOP and undefined codes: no state change.
  - At most one register is written per cycle.
- R0 is an ordinary writable register; there is no hard-wired zero.
- Reads are combinational. Read order of precedence:
  - When rst is high: return the stored values, with no bypass.
  - Otherwise, if wb_reg_op = REG and wb_addr equals the port address: return wb_data.
  - Otherwise: return the stored register.
- Special outputs follow the same rule. For example, IH_data = wb_data when wb_reg_op = IH and rst is low, else the stored IH.
- Both read ports may address the same register, and both may hit the bypass in the same cycle; each returns wb_data independently.
- A REG write never bypasses to the special outputs, and a special write never bypasses to reg1_data or reg2_data.

## Timing
- Write latency: one edge. The value is stored on the edge that ends the cycle in which it was presented.
- Read latency: zero cycles, combinational from the address, the stored value and the bypass inputs.
- With the bypass, ID sees a WB result in the same cycle it is presented. There is no one-cycle read-after-write gap.
- Outputs after the reset edge, with no write pending:
  - reg1_data = reg2_data = 0
  - IH_data = IH_RESET
  - SP_data = SP_RESET
  - T_data = 0
- Outputs while rst is high: stored values only. They reflect the reset values from the first edge with rst high onward.
- Reset asserted mid-stream: a write in the same cycle as the reset edge is lost, and the reset values win. A write in the first cycle after rst falls is accepted normally.
- No handshake and no stall input. The upstream WB stage must drive NOP whenever its pipeline slot is a bubble.
- No combinational path from any read address to any write input. Read-side paths from wb_* inputs to outputs are allowed and expected.

## Test plan
- Reset: hold rst for 2 cycles with wb_reg_op = REG, wb_addr = 3, wb_data = 16'h1234. After release, R3 = 0, SP_data = 16'hBF10, IH_data = 0, T_data = 0.
- Write then read: write R5 = 16'hA5A5 in cycle n, drive NOP in cycle n+1 with reg1_addr = 5. reg1_data = 16'hA5A5 in cycle n+1.
- Bypass: in one cycle, drive wb_reg_op = REG, wb_addr = 2, wb_data = 16'h00FF, reg1_addr = reg2_addr = 2, with stored R2 = 0. Both read ports return 16'h00FF that cycle; R2 = 16'h00FF in the following cycle.
- Special isolation: write SP = 16'h8000 with reg1_addr = 3, then write R3 = 16'h7777.
  - During the SP write, SP_data = 16'h8000 and reg1_data is unchanged.
  - During the R3 write, SP_data stays 16'h8000 and IH_data and T_data are unchanged.
- Undefined op and reset mid-stream:
  - wb_reg_op = 6 with wb_data = 16'hFFFF changes no register.
  - A T write of 16'h0001 in the same cycle as a reset edge leaves T_data = 0 after the edge.

Source files
------------

// File: rtl/reg_file_wb.sv
// Write-back register file: R0-R7 plus IH, SP and T, one commit per cycle,
// with a same-cycle write-through bypass on every read output.
module reg_file_wb #(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = 16'hBF10,
  parameter logic [DATA_WIDTH-1:0] IH_RESET   = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            wb_reg_op,
  input  logic [2:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [2:0]            reg1_addr,
  input  logic [2:0]            reg2_addr,
  output logic [DATA_WIDTH-1:0] reg1_data,
  output logic [DATA_WIDTH-1:0] reg2_data,
  output logic [DATA_WIDTH-1:0] IH_data,
  output logic [DATA_WIDTH-1:0] SP_data,
  output logic [DATA_WIDTH-1:0] T_data
);

  localparam logic [2:0] OP_REG = 3'd1;
  localparam logic [2:0] OP_IH  = 3'd2;
  localparam logic [2:0] OP_SP  = 3'd3;
  localparam logic [2:0] OP_T   = 3'd4;

  logic [DATA_WIDTH-1:0] regs_q [8];
  logic [DATA_WIDTH-1:0] regs_d [8];
  logic [DATA_WIDTH-1:0] ih_q, ih_d;
  logic [DATA_WIDTH-1:0] sp_q, sp_d;
  logic [DATA_WIDTH-1:0] t_q, t_d;

  always_comb begin
    regs_d = regs_q;
    ih_d   = ih_q;
    sp_d   = sp_q;
    t_d    = t_q;
    case (wb_reg_op)
      OP_REG:  regs_d[wb_addr] = wb_data;
      OP_IH:   ih_d = wb_data;
      OP_SP:   sp_d = wb_data;
      OP_T:    t_d  = wb_data;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      ih_q <= IH_RESET;
      sp_q <= SP_RESET;
      t_q  <= '0;
    end else begin
      regs_q <= regs_d;
      ih_q   <= ih_d;
      sp_q   <= sp_d;
      t_q    <= t_d;
    end
  end

  // Bypass is suppressed during reset so outputs show stored values only.
  logic byp_reg, byp_ih, byp_sp, byp_t;
  assign byp_reg = !rst && (wb_reg_op == OP_REG);
  assign byp_ih  = !rst && (wb_reg_op == OP_IH);
  assign byp_sp  = !rst && (wb_reg_op == OP_SP);
  assign byp_t   = !rst && (wb_reg_op == OP_T);

  assign reg1_data = (byp_reg && wb_addr == reg1_addr) ? wb_data : regs_q[reg1_addr];
  assign reg2_data = (byp_reg && wb_addr == reg2_addr) ? wb_data : regs_q[reg2_addr];
  assign IH_data   = byp_ih ? wb_data : ih_q;
  assign SP_data   = byp_sp ? wb_data : sp_q;
  assign T_data    = byp_t  ? wb_data : t_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  wb_reg_op, wb_addr, reg1_addr, reg2_addr;
  logic [15:0] wb_data;
  logic [15:0] reg1_data, reg2_data, IH_data, SP_data, T_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mr [8];
  logic [15:0] mih, msp, mt;

  always #5 clk = ~clk;

  reg_file_wb #(.DATA_WIDTH(16), .SP_RESET(16'hBF10), .IH_RESET(16'h0000)) dut (
    .clk(clk), .rst(rst), .wb_reg_op(wb_reg_op), .wb_addr(wb_addr), .wb_data(wb_data),
    .reg1_addr(reg1_addr), .reg2_addr(reg2_addr), .reg1_data(reg1_data),
    .reg2_data(reg2_data), .IH_data(IH_data), .SP_data(SP_data), .T_data(T_data)
  );

  // Advance one edge, updating the model from the inputs held across it.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) mr[i] = 16'h0;
      mih = 16'h0000; msp = 16'hBF10; mt = 16'h0;
    end else begin
      if (wb_reg_op == 3'd1) mr[wb_addr] = wb_data;
      else if (wb_reg_op == 3'd2) mih = wb_data;
      else if (wb_reg_op == 3'd3) msp = wb_data;
      else if (wb_reg_op == 3'd4) mt = wb_data;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; wb_reg_op = 3'd1; wb_addr = 3'd3; wb_data = 16'h1234;
    reg1_addr = 3'd3; reg2_addr = 3'd3;
    tick();
    #3;
    n_cmp++; if (reg1_data !== 16'h0) begin n_err++; $display("FAIL rst_hold_r3: got %h want 0000", reg1_data); end
    tick();
    rst = 0; wb_reg_op = 3'd0;
    #3;
    n_cmp++; if (reg1_data !== 16'h0) begin n_err++; $display("FAIL rst_r3: got %h want 0000", reg1_data); end
    n_cmp++; if (SP_data !== 16'hBF10) begin n_err++; $display("FAIL rst_sp: got %h want bf10", SP_data); end
    n_cmp++; if (IH_data !== 16'h0) begin n_err++; $display("FAIL rst_ih: got %h want 0000", IH_data); end
    n_cmp++; if (T_data !== 16'h0) begin n_err++; $display("FAIL rst_t: got %h want 0000", T_data); end
    reg2_addr = 3'd0;
    #1;
    n_cmp++; if (reg2_data !== 16'h0) begin n_err++; $display("FAIL rst_r0: got %h want 0000", reg2_data); end
    tick();
  endtask

  task automatic test_write_read();
    wb_reg_op = 3'd1; wb_addr = 3'd5; wb_data = 16'hA5A5;
    tick();
    wb_reg_op = 3'd0; reg1_addr = 3'd5;
    #3;
    n_cmp++; if (reg1_data !== 16'hA5A5) begin n_err++; $display("FAIL write_read_r5: got %h want a5a5", reg1_data); end
    tick();
  endtask

  task automatic test_bypass();
    wb_reg_op = 3'd1; wb_addr = 3'd2; wb_data = 16'h00FF; reg1_addr = 3'd2; reg2_addr = 3'd2;
    #3;
    n_cmp++; if (reg1_data !== 16'h00FF) begin n_err++; $display("FAIL bypass_p1: got %h want 00ff", reg1_data); end
    n_cmp++; if (reg2_data !== 16'h00FF) begin n_err++; $display("FAIL bypass_p2: got %h want 00ff", reg2_data); end
    tick();
    wb_reg_op = 3'd0;
    #3;
    n_cmp++; if (reg1_data !== 16'h00FF) begin n_err++; $display("FAIL bypass_stored: got %h want 00ff", reg1_data); end
    tick();
  endtask

  task automatic test_special_isolation();
    reg1_addr = 3'd3; wb_reg_op = 3'd3; wb_addr = 3'd3; wb_data = 16'h8000;
    #3;
    n_cmp++; if (SP_data !== 16'h8000) begin n_err++; $display("FAIL iso_sp_byp: got %h want 8000", SP_data); end
    n_cmp++; if (reg1_data !== 16'h0) begin n_err++; $display("FAIL iso_r3_nobyp: got %h want 0000", reg1_data); end
    tick();
    wb_reg_op = 3'd1; wb_data = 16'h7777;
    #3;
    n_cmp++; if (SP_data !== 16'h8000) begin n_err++; $display("FAIL iso_sp_keep: got %h want 8000", SP_data); end
    n_cmp++; if (IH_data !== 16'h0) begin n_err++; $display("FAIL iso_ih_keep: got %h want 0000", IH_data); end
    n_cmp++; if (T_data !== 16'h0) begin n_err++; $display("FAIL iso_t_keep: got %h want 0000", T_data); end
    n_cmp++; if (reg1_data !== 16'h7777) begin n_err++; $display("FAIL iso_r3_byp: got %h want 7777", reg1_data); end
    tick();
  endtask

  task automatic test_undef_and_midreset();
    wb_reg_op = 3'd6; wb_addr = 3'd5; wb_data = 16'hFFFF; reg1_addr = 3'd5; reg2_addr = 3'd2;
    #3;
    n_cmp++; if (reg1_data !== 16'hA5A5) begin n_err++; $display("FAIL undef_byp_r5: got %h want a5a5", reg1_data); end
    n_cmp++; if (T_data !== 16'h0) begin n_err++; $display("FAIL undef_byp_t: got %h want 0000", T_data); end
    tick();
    wb_reg_op = 3'd0;
    #3;
    n_cmp++; if (reg1_data !== 16'hA5A5) begin n_err++; $display("FAIL undef_r5: got %h want a5a5", reg1_data); end
    n_cmp++; if (reg2_data !== 16'h00FF) begin n_err++; $display("FAIL undef_r2: got %h want 00ff", reg2_data); end
    n_cmp++; if (SP_data !== 16'h8000) begin n_err++; $display("FAIL undef_sp: got %h want 8000", SP_data); end
    n_cmp++; if (IH_data !== 16'h0) begin n_err++; $display("FAIL undef_ih: got %h want 0000", IH_data); end
    tick();
    // T write coincident with a reset edge must be lost.
    rst = 1; wb_reg_op = 3'd4; wb_data = 16'h0001;
    #3;
    n_cmp++; if (T_data !== 16'h0) begin n_err++; $display("FAIL midrst_t_nobyp: got %h want 0000", T_data); end
    n_cmp++; if (SP_data !== 16'h8000) begin n_err++; $display("FAIL midrst_sp_pre: got %h want 8000", SP_data); end
    tick();
    rst = 0; wb_reg_op = 3'd0;
    #3;
    n_cmp++; if (T_data !== 16'h0) begin n_err++; $display("FAIL midrst_t: got %h want 0000", T_data); end
    n_cmp++; if (SP_data !== 16'hBF10) begin n_err++; $display("FAIL midrst_sp: got %h want bf10", SP_data); end
    n_cmp++; if (reg1_data !== 16'h0) begin n_err++; $display("FAIL midrst_r5: got %h want 0000", reg1_data); end
    wb_reg_op = 3'd4; wb_data = 16'h0001;
    tick();
    wb_reg_op = 3'd0;
    #3;
    n_cmp++; if (T_data !== 16'h0001) begin n_err++; $display("FAIL postrst_t: got %h want 0001", T_data); end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] e1, e2, eih, esp, et;
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 31) == 0);
      wb_reg_op = 3'($urandom_range(0, 7));
      wb_addr   = 3'($urandom_range(0, 7));
      wb_data   = 16'($urandom);
      reg1_addr = 3'($urandom_range(0, 7));
      reg2_addr = ($urandom_range(0, 3) == 0) ? reg1_addr : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) reg1_addr = wb_addr;
      e1  = (!rst && wb_reg_op == 3'd1 && wb_addr == reg1_addr) ? wb_data : mr[reg1_addr];
      e2  = (!rst && wb_reg_op == 3'd1 && wb_addr == reg2_addr) ? wb_data : mr[reg2_addr];
      eih = (!rst && wb_reg_op == 3'd2) ? wb_data : mih;
      esp = (!rst && wb_reg_op == 3'd3) ? wb_data : msp;
      et  = (!rst && wb_reg_op == 3'd4) ? wb_data : mt;
      #3;
      n_cmp++; if (reg1_data !== e1) begin n_err++; $display("FAIL rnd_reg1 cyc %0d: got %h want %h", n, reg1_data, e1); end
      n_cmp++; if (reg2_data !== e2) begin n_err++; $display("FAIL rnd_reg2 cyc %0d: got %h want %h", n, reg2_data, e2); end
      n_cmp++; if (IH_data !== eih) begin n_err++; $display("FAIL rnd_ih cyc %0d: got %h want %h", n, IH_data, eih); end
      n_cmp++; if (SP_data !== esp) begin n_err++; $display("FAIL rnd_sp cyc %0d: got %h want %h", n, SP_data, esp); end
      n_cmp++; if (T_data !== et) begin n_err++; $display("FAIL rnd_t cyc %0d: got %h want %h", n, T_data, et); end
      tick();
    end
    rst = 0; wb_reg_op = 3'd0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mr[i] = 16'h0;
    mih = 16'h0; msp = 16'hBF10; mt = 16'h0;
    test_reset();
    test_write_read();
    test_bypass();
    test_special_isolation();
    test_undef_and_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
